// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM state encoding
// and the digit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-digit operation still needs a 1-bit counter register.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_sub_digit_adder.sv
// Combinational ripple chain of DIGIT full adders. It also exports the carry
// into the top bit, so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin : ripple
        logic c;
        c        = cin;
        s        = '0;
        c_msb_in = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb_in = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_adder_sub.sv
// Digit-serial WIDTH-bit add/subtract. Each operation runs NDIG = WIDTH/DIGIT
// cycles through a registered carry, with valid/ready handshakes on both sides.
module serial_adder_sub
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. out_valid and the result stay stable until accepted, and
    // in_ready is only offered in IDLE.

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, sum_r;
    logic             carry, cout_r, ovf_r;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_s;
    logic             d_cout, d_cmsb;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a        (a_sr[DIGIT-1:0]),
        .b        (b_sr[DIGIT-1:0]),
        .cin      (carry),
        .s        (d_s),
        .cout     (d_cout),
        .c_msb_in (d_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted on capture and the carry seeded.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= d_cout;
                    sum_r <= (sum_r >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout_r <= d_cout;
                        ovf_r  <= d_cmsb ^ d_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: a 16/4 instance and a 16/16 instance, directed
// vectors, and a cycle-by-cycle compare against an arithmetic reference model.
module tb_serial_adder_sub;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid [2];
    logic         in_ready [2];
    logic [W-1:0] a        [2];
    logic [W-1:0] b        [2];
    logic         cin      [2];
    logic         sub_m    [2];
    logic         out_valid[2];
    logic         out_ready[2];
    logic [W-1:0] sum      [2];
    logic         cout     [2];
    logic         ovf      [2];
    logic [1:0]   dbg      [2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    serial_adder_sub #(.WIDTH(W), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub_m[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]), .dbg_state(dbg[0])
    );

    serial_adder_sub #(.WIDTH(W), .DIGIT(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub_m[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]), .dbg_state(dbg[1])
    );

    function automatic int nd(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 computing (left cycles remaining), 2 holding result.
    int           m_phase[2];
    int           m_left [2];
    logic [W-1:0] m_sum  [2];
    logic         m_cout [2];
    logic         m_ovf  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_phase[i] = 0;
                m_sum[i]   = '0;
                m_cout[i]  = 1'b0;
                m_ovf[i]   = 1'b0;
            end else begin
                case (m_phase[i])
                    0: if (in_valid[i]) begin
                        logic [W-1:0] bm;
                        logic [W:0]   r;
                        bm = sub_m[i] ? ~b[i] : b[i];
                        r  = {1'b0, a[i]} + {1'b0, bm} + (W+1)'(sub_m[i] ? 1'b1 : cin[i]);
                        m_sum[i]   = r[W-1:0];
                        m_cout[i]  = r[W];
                        m_ovf[i]   = (a[i][W-1] == bm[W-1]) && (r[W-1] != a[i][W-1]);
                        m_left[i]  = nd(i);
                        m_phase[i] = 1;
                    end
                    1: begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_phase[i] = 2;
                    end
                    default: if (out_ready[i]) m_phase[i] = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("cyc_in_ready", i, 32'(in_ready[i]), 32'(m_phase[i] == 0 && !rst));
                chk("cyc_out_valid", i, 32'(out_valid[i]), 32'(m_phase[i] == 2));
                if (m_phase[i] != 1) begin
                    chk("cyc_sum", i, 32'(sum[i]), 32'(m_sum[i]));
                    chk("cyc_cout", i, 32'(cout[i]), 32'(m_cout[i]));
                    chk("cyc_ovf", i, 32'(ovf[i]), 32'(m_ovf[i]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int i, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ci, input logic sb, input logic [W-1:0] es,
                          input logic ec, input logic eo, input int hold, input bit keep);
        int n;
        n = 0;
        while (!in_ready[i] && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", i, 32'(in_ready[i]), 32'd1);
        a[i] = aa; b[i] = bb; cin[i] = ci; sub_m[i] = sb; in_valid[i] = 1'b1;
        step();
        in_valid[i] = keep;
        a[i] = W'($urandom); b[i] = W'($urandom);
        cin[i] = 1'($urandom_range(0, 1)); sub_m[i] = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_valid[i] && n < 40) begin
            step();
            n++;
            if (keep) begin
                a[i] = W'($urandom);
                b[i] = W'($urandom);
            end
        end
        chk("latency", i, 32'(n), 32'(nd(i)));
        in_valid[i] = 1'b0;
        chk("res_sum", i, 32'(sum[i]), 32'(es));
        chk("res_cout", i, 32'(cout[i]), 32'(ec));
        chk("res_ovf", i, 32'(ovf[i]), 32'(eo));
        repeat (hold) begin
            step();
            chk("hold_valid", i, 32'(out_valid[i]), 32'd1);
            chk("hold_in_ready", i, 32'(in_ready[i]), 32'd0);
            chk("hold_sum", i, 32'(sum[i]), 32'(es));
        end
        out_ready[i] = 1'b1;
        step();
        out_ready[i] = 1'b0;
        chk("drained", i, 32'(out_valid[i]), 32'd0);
        chk("kept_sum", i, 32'(sum[i]), 32'(es));
        chk("idle_ready", i, 32'(in_ready[i]), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 0; a[i] = '0; b[i] = '0; cin[i] = 0; sub_m[i] = 0; out_ready[i] = 0;
        end
        step();
        chk_en = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", i, 32'(in_ready[i]), 32'd0);
            chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
            chk("rst_sum", i, 32'(sum[i]), 32'd0);
            chk("rst_cout", i, 32'(cout[i]), 32'd0);
            chk("rst_ovf", i, 32'(ovf[i]), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("post_rst_ready", 0, 32'(in_ready[0]), 32'd1);

        // out_ready while idle must not do anything
        out_ready[0] = 1'b1;
        repeat (3) step();
        out_ready[0] = 1'b0;

        run_op(0, 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0, 0);
        run_op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0, 1);
        run_op(0, 16'h7FFE, 16'h0000, 1, 0, 16'h7FFF, 0, 0, 0, 0);
        run_op(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0, 0);
        run_op(0, 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0, 0);
        run_op(0, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 10, 0);
        run_op(0, 16'h1234, 16'h1234, 0, 1, 16'h0000, 1, 0, 0, 1);

        // Reset two cycles into a computation: nothing may come out.
        a[0] = 16'h1234; b[0] = 16'h4321; cin[0] = 0; sub_m[0] = 0; in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("midrst_sum", 0, 32'(sum[0]), 32'd0);
        chk("midrst_in_ready", 0, 32'(in_ready[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 0, 32'(in_ready[0]), 32'd1);
        repeat (6) step();
        chk("midrst_no_output", 0, 32'(out_valid[0]), 32'd0);
        run_op(0, 16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0, 0, 0);

        run_op(1, 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0, 0);
        run_op(1, 16'hFFFF, 16'h0001, 1, 0, 16'h0001, 1, 0, 3, 0);
        run_op(1, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0, 0);

        repeat (2) step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
- Parametrised, digit-serial adder/subtractor; the sequential successor to the single-bit structural full adder.
- Processes WIDTH-bit two's-complement operands DIGIT bits per clock through a registered carry.
- Uses a valid/ready handshake on input and output.
- Intended as the shared arithmetic unit for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width in bits; WIDTH >= 2.
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT == 0 is required; elaboration error otherwise.
- Derived constant NDIG = WIDTH/DIGIT. This is the number of compute cycles.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
- out_valid  output  1  result held stable
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry out (in sub mode: 1 = no borrow)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset and clock: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: while rst is high at a clock edge, the following apply.
  - State goes to IDLE.
  - in_ready=0 during the reset cycle, then 1 in IDLE.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - Internal operand, carry and digit-count registers are cleared.
  - Reset overrides everything, including mid-computation. An in-flight operation is discarded and no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid the block captures a into the A shift register.
  - It captures (sub ? ~b : b) into the B shift register.
  - The carry register is loaded with (sub ? 1 : cin).
  - The digit counter is set to 0, and the FSM moves to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the low DIGIT bits of the A/B registers and the carry enter the digit adder.
  - The digit sum shifts into the result register from the MSB side.
  - A/B shift right by DIGIT, and the carry register takes the digit carry-out.
  - On the last digit (counter == NDIG-1):
    - register cout = digit carry-out.
    - register ovf = carry into bit DIGIT-1 of that digit XOR digit carry-out.
    - go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are stable and unchanged until the handshake completes.
  - When out_ready=1, the FSM goes to IDLE and out_valid falls next cycle. sum, cout and ovf retain their values.
  - in_ready stays 0 in DONE. There is no same-cycle accept with output drain.
- Latency:
  - The accepting edge is followed by exactly NDIG RUN cycles. out_valid asserts on the edge ending the last RUN cycle.
  - Minimum throughput is one operation per NDIG+2 cycles when out_ready is held high.
- Boundary conditions:
  - DIGIT == WIDTH gives NDIG=1, so RUN lasts 1 cycle.
  - in_valid held high outside IDLE is ignored, and input values are don't-care.
  - Inputs change after capture with no effect.
  - out_ready high outside DONE has no effect.
  - Arithmetic wraps modulo 2^WIDTH.
  - The digit counter width is clog2(NDIG), minimum 1.

Decomposition:
- Package serial_adder_pkg holds the state enum (IDLE, RUN, DONE) and the function computing the counter width.
- One sub-module, digit_adder (parameter DIGIT): combinational ripple chain of DIGIT single-bit full adders.
  - Inputs: a, b, cin.
  - Outputs: s, cout, c_msb_in, where c_msb_in is the carry into the top bit and feeds the ovf calculation.

Test Plan:
- All cases use WIDTH=16, DIGIT=4 unless stated.
- Add, no carry: a=0x1234, b=0x4321, sub=0, cin=0 → after 4 RUN cycles out_valid=1, sum=0x5555, cout=0, ovf=0.
- Unsigned wrap: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
- Carry-in and signed overflow: a=0x7FFE, b=0x0000, cin=1 → 0x7FFF, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → sum, cout, ovf and out_valid stable and in_ready=0 throughout. Raise out_ready → IDLE next cycle, then accept a new op.
- Reset mid-RUN: assert rst after 2 RUN cycles → next cycle out_valid=0, sum=0, in_ready returns 1 after release. Repeat the first add case with DIGIT=16 (NDIG=1) → 1-cycle RUN, same result.
